// File: rtl/systolic_ws_ctrl.sv
// Weight-stationary sequencer: loads one weight tile into the systolic array, streams activation
// vectors, and realigns the skewed column sums into a credit-protected show-ahead result FIFO.
module systolic_ws_ctrl #(
    parameter int DATA_WIDTH     = 16,
    parameter int SUM_WIDTH      = 16,
    parameter int SYSTOLIC_WIDTH = 4,
    parameter int ARR_LAT        = SYSTOLIC_WIDTH + 1,
    parameter int FIFO_DEPTH     = 8,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 reuse_w,
    input  logic [CNT_WIDTH-1:0]                 num_vec,
    input  logic                                 w_valid,
    output logic                                 w_ready,
    input  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] w_data,
    input  logic                                 act_valid,
    output logic                                 act_ready,
    input  logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] act_data,
    output logic                                 res_valid,
    input  logic                                 res_ready,
    output logic [SYSTOLIC_WIDTH*SUM_WIDTH-1:0]  res_data,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 arr_mode,
    output logic                                 arr_state,
    output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] arr_a_raw,
    output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] arr_b_raw,
    output logic [SYSTOLIC_WIDTH*DATA_WIDTH-1:0] arr_sum_raw,
    input  logic [SYSTOLIC_WIDTH*SUM_WIDTH-1:0]  arr_sum_out,
    output logic [2:0]                           dbg_state
);

    localparam int N  = SYSTOLIC_WIDTH;
    localparam int P  = ARR_LAT + N - 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(P + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
    localparam logic [AW-1:0]        PTR_ONE = 1;
    localparam logic [AW:0]          FC_ONE  = 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SETTLE  = 3'd2,
        S_COMPUTE = 3'd3,
        S_DRAIN   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                 state_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   num_vec_q;
    logic                   loaded_q;
    logic [P-1:0]           vpipe_q, vpipe_d;
    logic [IW-1:0]          inflight;
    logic                   credit_ok;
    logic                   act_acc;
    logic [AW:0]            fifo_cnt_q;
    logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [N*SUM_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [N*SUM_WIDTH-1:0] wr_data;
    logic                   fifo_wr, fifo_rd;

    // Valid/ready: a transfer happens on a rising edge where both are high; every ready here
    // depends only on registered state, never on the matching valid.
    always_comb begin
        w_ready   = 1'b0;
        act_ready = 1'b0;
        arr_state = 1'b1;
        arr_a_raw = '0;
        arr_b_raw = '0;
        case (state_q)
            // Stays 0 only until the first job so IDLE never shifts resident weights away.
            S_IDLE:   arr_state = loaded_q;
            S_LOAD: begin
                w_ready   = 1'b1;
                arr_state = ~w_valid;
                if (w_valid) arr_b_raw = w_data;
            end
            S_SETTLE: arr_state = 1'b0;
            S_COMPUTE: begin
                act_ready = credit_ok && (cnt_q < num_vec_q);
                if (act_valid && act_ready) arr_a_raw = act_data;
            end
            default: ;
        endcase
    end

    assign act_acc     = act_valid && act_ready;
    assign arr_mode    = 1'b0;
    assign arr_sum_raw = '0;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign dbg_state   = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            num_vec_q <= '0;
            loaded_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    num_vec_q <= num_vec;
                    cnt_q     <= '0;
                    loaded_q  <= 1'b1;
                    if (num_vec == '0)  state_q <= S_DONE;
                    else if (reuse_w)   state_q <= S_COMPUTE;
                    else                state_q <= S_LOAD;
                end
                S_LOAD: if (w_valid) begin
                    if (cnt_q == CNT_WIDTH'(N - 1)) begin
                        cnt_q   <= '0;
                        state_q <= S_SETTLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                S_SETTLE: state_q <= S_COMPUTE;
                S_COMPUTE: if (act_acc) begin
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q + CNT_ONE == num_vec_q) state_q <= S_DRAIN;
                end
                S_DRAIN: if (vpipe_d == '0) state_q <= S_DONE;
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // One bit per issued slot; the oldest stage lines up with the fully deskewed sums.
    assign vpipe_d = {vpipe_q[P-2:0], act_acc};

    always_ff @(posedge clk) begin
        if (rst) vpipe_q <= '0;
        else     vpipe_q <= vpipe_d;
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < P; i++) inflight = inflight + IW'(vpipe_q[i]);
    end

    assign credit_ok = (32'(fifo_cnt_q) + 32'(inflight)) < 32'(FIFO_DEPTH);

    for (genvar j = 0; j < N; j++) begin : g_lane
        if (j == N - 1) begin : g_direct
            assign wr_data[j*SUM_WIDTH +: SUM_WIDTH] = arr_sum_out[j*SUM_WIDTH +: SUM_WIDTH];
        end else begin : g_dly
            localparam int D = N - 1 - j;
            logic [SUM_WIDTH-1:0] d_q [D];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < D; k++) d_q[k] <= '0;
                end else begin
                    d_q[0] <= arr_sum_out[j*SUM_WIDTH +: SUM_WIDTH];
                    for (int k = 1; k < D; k++) d_q[k] <= d_q[k-1];
                end
            end
            assign wr_data[j*SUM_WIDTH +: SUM_WIDTH] = d_q[D-1];
        end
    end

    assign fifo_wr   = vpipe_q[P-1];
    assign res_valid = (fifo_cnt_q != '0);
    assign fifo_rd   = res_valid && res_ready;
    assign res_data  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (fifo_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (fifo_wr) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (fifo_rd) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({fifo_wr, fifo_rd})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + FC_ONE;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - FC_ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_ws_ctrl.sv
// Bench for systolic_ws_ctrl: a pin-level systolic array model plus a matrix-product
// scoreboard that predicts every result vector from the weights and activations sent.
module tb_systolic_ws_ctrl;

    localparam int DW = 16;
    localparam int SW = 16;
    localparam int N  = 4;
    localparam int AL = N + 1;
    localparam int FD = 8;
    localparam int CW = 16;
    localparam int P  = AL + N - 1;
    localparam int JOB_BUDGET   = 400;
    localparam int DRAIN_BUDGET = 200;

    logic              clk = 1'b0;
    logic              rst, start, reuse_w;
    logic [CW-1:0]     num_vec;
    logic              w_valid, w_ready, act_valid, act_ready, res_valid, res_ready;
    logic [N*DW-1:0]   w_data, act_data, arr_a_raw, arr_b_raw, arr_sum_raw;
    logic [N*SW-1:0]   res_data, arr_sum_out;
    logic              busy, done, arr_mode, arr_state;
    logic [2:0]        dbg_state;

    systolic_ws_ctrl #(
        .DATA_WIDTH(DW), .SUM_WIDTH(SW), .SYSTOLIC_WIDTH(N),
        .ARR_LAT(AL), .FIFO_DEPTH(FD), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .reuse_w(reuse_w), .num_vec(num_vec),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy), .done(done), .arr_mode(arr_mode), .arr_state(arr_state),
        .arr_a_raw(arr_a_raw), .arr_b_raw(arr_b_raw), .arr_sum_raw(arr_sum_raw),
        .arr_sum_out(arr_sum_out), .dbg_state(dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    // ---------------- systolic array model ----------------
    logic [DW-1:0] b_in_m  [N];
    logic [DW-1:0] b_reg_m [N][N];
    logic [SW-1:0] hist    [P][N];

    function automatic logic [SW-1:0] arr_col(input logic [N*DW-1:0] a,
                                              input logic [N*DW-1:0] s, input int j);
        logic [SW-1:0] acc;
        logic [31:0]   prod;
        acc = s[j*DW +: DW];
        for (int i = 0; i < N; i++) begin
            prod = 32'(a[i*DW +: DW]) * 32'(b_reg_m[i][j]);
            acc  = acc + prod[SW-1:0];
        end
        return acc;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                b_in_m[i] <= '0;
                for (int j = 0; j < N; j++) b_reg_m[i][j] <= '0;
            end
            for (int k = 0; k < P; k++)
                for (int j = 0; j < N; j++) hist[k][j] <= '0;
        end else begin
            if (arr_state == 1'b0) begin
                for (int j = 0; j < N; j++) begin
                    b_in_m[j]     <= arr_b_raw[j*DW +: DW];
                    b_reg_m[0][j] <= b_in_m[j];
                end
                for (int i = 1; i < N; i++)
                    for (int j = 0; j < N; j++) b_reg_m[i][j] <= b_reg_m[i-1][j];
            end
            for (int j = 0; j < N; j++)
                hist[0][j] <= arr_state ? arr_col(arr_a_raw, arr_sum_raw, j) : '0;
            for (int k = 1; k < P; k++)
                for (int j = 0; j < N; j++) hist[k][j] <= hist[k-1][j];
        end
    end

    always_comb begin
        arr_sum_out = '0;
        for (int j = 0; j < N; j++) arr_sum_out[j*SW +: SW] = hist[AL+j-1][j];
    end

    // ---------------- scoreboard and reference ----------------
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [SW-1:0]   w_mat [N][N];
    logic [N*DW-1:0] act_src [$];
    logic [N*SW-1:0] exp_q [$];
    logic [N*SW-1:0] last_res;
    int n_acc, n_res, n_wrdy, done_cnt;
    int first_wacc_cyc, first_acc_cyc, first_rv_cyc, last_acc_cyc, done_cyc;
    bit last_w_acc, last_act_acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result lane j = sum over rows i of a[i] * W[i][j], modulo 2^SW.
    function automatic logic [N*SW-1:0] ref_mac(input logic [N*DW-1:0] a);
        logic [N*SW-1:0] r;
        logic [31:0]     acc;
        r = '0;
        for (int j = 0; j < N; j++) begin
            acc = '0;
            for (int i = 0; i < N; i++) acc = acc + 32'(a[i*DW +: DW]) * 32'(w_mat[i][j]);
            r[j*SW +: SW] = acc[SW-1:0];
        end
        return r;
    endfunction

    function automatic logic [N*DW-1:0] pack_row(input int i);
        logic [N*DW-1:0] r;
        for (int j = 0; j < N; j++) r[j*DW +: DW] = w_mat[i][j];
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        last_w_acc   = w_valid && w_ready;
        last_act_acc = act_valid && act_ready;
        if (w_ready) n_wrdy++;
        if (last_w_acc && first_wacc_cyc < 0) first_wacc_cyc = cyc;
        if (last_act_acc) begin
            exp_q.push_back(ref_mac(act_data));
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
            n_acc++;
        end
        if (res_valid && first_rv_cyc < 0) first_rv_cyc = cyc;
        if (res_valid && res_ready) begin
            n_res++;
            last_res = res_data;
            if (exp_q.size() == 0) check("res_extra", n_res, n_acc);
            else                   check("res_data", res_data, exp_q.pop_front());
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string p);
        check({p, "_w_ready"},     w_ready,     0);
        check({p, "_act_ready"},   act_ready,   0);
        check({p, "_res_valid"},   res_valid,   0);
        check({p, "_busy"},        busy,        0);
        check({p, "_done"},        done,        0);
        check({p, "_arr_state"},   arr_state,   0);
        check({p, "_arr_mode"},    arr_mode,    0);
        check({p, "_arr_a_raw"},   arr_a_raw,   0);
        check({p, "_arr_b_raw"},   arr_b_raw,   0);
        check({p, "_arr_sum_raw"}, arr_sum_raw, 0);
    endtask

    // act_pat: 0 = always valid, 1 = toggling, 2 = random. abort_at > 0 returns mid-job.
    task automatic run_job(input bit reuse, input int nv, input int act_pat, input int rr_hold,
                           input bit rr_rand, input bit w_gap, input int abort_at);
        int rows_sent, vi, k;
        rows_sent = 0; vi = 0; k = 0;
        n_acc = 0; n_res = 0; n_wrdy = 0; done_cnt = 0;
        first_wacc_cyc = -1; first_acc_cyc = -1; first_rv_cyc = -1;
        last_acc_cyc = -1; done_cyc = -1;
        start = 1'b1; reuse_w = reuse; num_vec = CW'(nv);
        w_valid = 1'b0; act_valid = 1'b0; res_ready = 1'b0;
        tick();
        start = 1'b0;
        while (done_cnt == 0 && k < JOB_BUDGET) begin
            if (abort_at > 0 && n_acc == abort_at) break;
            w_valid = (rows_sent < N) && (!w_gap || $urandom_range(0, 1) == 1);
            w_data  = (rows_sent < N) ? pack_row(N - 1 - rows_sent) : '0;
            case (act_pat)
                0:       act_valid = (vi < nv);
                1:       act_valid = (vi < nv) && (k % 2 == 1);
                default: act_valid = (vi < nv) && ($urandom_range(0, 2) != 0);
            endcase
            act_data  = (vi < nv) ? act_src[vi] : '0;
            res_ready = (k < rr_hold) ? 1'b0 : (rr_rand ? 1'($urandom_range(0, 1)) : 1'b1);
            if (rr_hold > 0 && k == rr_hold) check("credit_accepts", n_acc, FD);
            tick();
            if (last_w_acc)   rows_sent++;
            if (last_act_acc) vi++;
            k++;
        end
        w_valid = 1'b0; act_valid = 1'b0;
        if (abort_at > 0) return;
        check("job_done", done_cnt, 1);
        k = 0;
        while (exp_q.size() > 0 && k < DRAIN_BUDGET) begin
            res_ready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            k++;
        end
        res_ready = 1'b0;
        tick();
        check("drained", exp_q.size(), 0);
        check("res_count", n_res, nv);
        check("done_once", done_cnt, 1);
        check("idle_busy", busy, 0);
        check("idle_res_valid", res_valid, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1; start = 1'b0; reuse_w = 1'b0; num_vec = '0;
        w_valid = 1'b0; w_data = '0; act_valid = 1'b0; act_data = '0; res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por");
        rst = 1'b0;

        // Identity weights pass activations straight through.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) w_mat[i][j] = (i == j) ? 16'd1 : 16'd0;
        act_src.delete();
        for (int v = 0; v < 4; v++) begin
            logic [N*DW-1:0] a;
            for (int j = 0; j < N; j++) a[j*DW +: DW] = DW'(4*v + j + 1);
            act_src.push_back(a);
        end
        run_job(1'b0, 4, 0, 0, 1'b0, 1'b0, 0);
        check("load_to_first_act", first_acc_cyc - first_wacc_cyc, N + 1);
        check("first_res_latency", first_rv_cyc - first_acc_cyc, P + 1);
        check("done_latency", done_cyc - last_acc_cyc, P + 1);
        check("ident_last", last_res, 64'h0010_000F_000E_000D);

        // W[i][j] = i+1 against all-ones gives 10 in every lane, then again reusing weights.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) w_mat[i][j] = SW'(i + 1);
        act_src.delete();
        for (int v = 0; v < 3; v++) act_src.push_back({4{16'd1}});
        run_job(1'b0, 3, 0, 0, 1'b0, 1'b1, 0);
        check("rowsum_res", last_res, {4{16'd10}});
        run_job(1'b1, 3, 0, 0, 1'b0, 1'b0, 0);
        check("reuse_res", last_res, {4{16'd10}});
        check("reuse_no_w_ready", n_wrdy, 0);

        // Toggling act_valid over six vectors.
        act_src.delete();
        for (int v = 0; v < 6; v++) act_src.push_back({N*DW/32{$urandom}});
        run_job(1'b1, 6, 1, 0, 1'b0, 1'b0, 0);

        // Back-pressure: only FIFO_DEPTH vectors may be accepted while results are held.
        act_src.delete();
        for (int v = 0; v < 12; v++) act_src.push_back({N*DW/32{$urandom}});
        run_job(1'b1, 12, 0, 30, 1'b0, 1'b0, 0);

        // Wrap: 0xFFFF * 2 in lane 0, 0x8000 * 3 in lane 1.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) w_mat[i][j] = '0;
        w_mat[0][0] = 16'd2;
        w_mat[1][1] = 16'd3;
        act_src.delete();
        act_src.push_back({16'd0, 16'd0, 16'h8000, 16'hFFFF});
        run_job(1'b0, 1, 0, 0, 1'b0, 1'b0, 0);
        check("wrap_lane0", last_res[15:0], 16'hFFFE);
        check("wrap_lane1", last_res[31:16], 16'h8000);

        // Zero-length job goes straight to done without loading.
        act_src.delete();
        run_job(1'b0, 0, 0, 0, 1'b0, 1'b0, 0);
        check("zero_no_w_ready", n_wrdy, 0);

        // Reset mid-compute, then a fresh job.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) w_mat[i][j] = SW'($urandom_range(0, 9));
        act_src.delete();
        for (int v = 0; v < 6; v++) act_src.push_back({N*DW/32{$urandom}});
        run_job(1'b0, 6, 0, 0, 1'b0, 1'b0, 2);
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("abort");
        exp_q.delete();
        n_acc = 0; n_res = 0; done_cnt = 0;
        res_ready = 1'b1;
        repeat (12) tick();
        res_ready = 1'b0;
        check("abort_no_done", done_cnt, 0);
        check("abort_no_results", n_res, 0);
        run_job(1'b0, 6, 0, 0, 1'b0, 1'b0, 0);

        // Randomised jobs: random weights, data, valid gaps and result back-pressure.
        for (int r = 0; r < 4; r++) begin
            int nv;
            nv = $urandom_range(1, 10);
            if (r != 2)
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++) w_mat[i][j] = SW'($urandom);
            act_src.delete();
            for (int v = 0; v < nv; v++) act_src.push_back({N*DW/32{$urandom}});
            run_job(r == 2, nv, 2, 0, 1'b1, 1'b1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
